// File: rtl/apb_arbiter_if.sv
// Requester-side and APB-side signals of the 4-way APB arbiter.
// master: the arbiter's view (it is the APB master toward the bus).
// slave:  the environment's view (requesters plus the APB completer).
interface apb_arbiter_if;
    logic [3:0]   req_i;
    logic [3:0]   req_write_i;
    logic [127:0] req_addr_i;
    logic [127:0] req_wdata_i;
    logic [3:0]   gnt_o;
    logic [3:0]   done_o;
    logic [31:0]  rdata_o;
    logic         err_o;
    logic         psel_o;
    logic         penable_o;
    logic         pwrite_o;
    logic [31:0]  paddr_o;
    logic [31:0]  pwdata_o;
    logic         pready_i;
    logic [31:0]  prdata_i;

    modport master (
        input  req_i, req_write_i, req_addr_i, req_wdata_i, pready_i, prdata_i,
        output gnt_o, done_o, rdata_o, err_o, psel_o, penable_o, pwrite_o,
               paddr_o, pwdata_o
    );

    modport slave (
        output req_i, req_write_i, req_addr_i, req_wdata_i, pready_i, prdata_i,
        input  gnt_o, done_o, rdata_o, err_o, psel_o, penable_o, pwrite_o,
               paddr_o, pwdata_o
    );
endinterface

// File: rtl/apb_arbiter.sv
// Four-requester round-robin arbiter driving a single APB master port.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES cycles without pready_i (done_o + err_o reported).
module apb_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    apb_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;       // index of the last granted requester
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`endif

    logic [1:0] win_idx;
    logic       win_vld;

    // Round-robin pick: scan from ptr_q+1 upward, ptr_q itself checked last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] cand;
            cand = ptr_q + i[1:0];
            if (!win_vld && bus.req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        done_d    = 4'b0;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        psel_d    = psel_q;
        penable_d = penable_q;
`ifdef APB_ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    // Pointer moves at grant time so a held request yields.
                    state_d = SETUP;
                    psel_d  = 1'b1;
                    ptr_d   = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    addr_d  = bus.req_addr_i[win_idx*32 +: 32];
                    wdata_d = bus.req_wdata_i[win_idx*32 +: 32];
                    write_d = bus.req_write_i[win_idx];
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    gnt_d     = 4'b0;
                    done_d    = gnt_q;
                    if (!write_q) rdata_d = bus.prdata_i;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: report completion with error, keep rdata.
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    gnt_d     = 4'b0;
                    done_d    = gnt_q;
                    err_d     = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                gnt_d     = 4'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd3;
            gnt_q     <= 4'b0;
            done_q    <= 4'b0;
            rdata_q   <= 32'b0;
            addr_q    <= 32'b0;
            wdata_q   <= 32'b0;
            write_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tcnt_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
`ifdef APB_ARB_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.done_o    = done_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.psel_o    = psel_q;
    assign bus.penable_o = penable_q;
    assign bus.pwrite_o  = write_q;
    assign bus.paddr_o   = addr_q;
    assign bus.pwdata_o  = wdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    assign bus.err_o     = err_q;
`else
    assign bus.err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_arbiter.sv
// Randomized bench for apb_arbiter with a transaction-level reference model.
module tb_apb_arbiter;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_arbiter_if bus();

    apb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int errors = 0;
    int checks = 0;

    // requester / completer stimulus state
    logic [3:0]  req;
    logic [31:0] r_addr [4];
    logic [31:0] r_wdata[4];
    logic        r_wr   [4];
    int          p_req;      // % chance an idle requester raises a request
    int          p_rdy;      // % chance pready is high in a cycle
    logic        rd_fixed;
    logic [31:0] rd_val;

    // reference model: transfer described by cycles elapsed since grant
    int          m_cyc;      // -1: no transfer, 0: first cycle, n>=1: n-th wait cycle
    int          m_own, m_last;
    logic [3:0]  m_done;
    logic        m_err;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic        m_write;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = -1; m_own = 0; m_last = 3; m_done = 0; m_err = 0;
        m_rdata = 0; m_addr = 0; m_wdata = 0; m_write = 0;
        req = 0;
        bus.req_i = 0; bus.req_write_i = 0; bus.req_addr_i = 0; bus.req_wdata_i = 0;
        bus.pready_i = 0; bus.prdata_i = 0;
    endtask

    // One clock: compare at negedge, update stimulus, advance the model.
    task automatic step();
        logic rdy;
        logic [31:0] prd;
        bit found;
        @(negedge clk);
        check("psel", {31'b0, bus.psel_o}, {31'b0, m_cyc >= 0});
        check("penable", {31'b0, bus.penable_o}, {31'b0, m_cyc >= 1});
        check("gnt", {28'b0, bus.gnt_o}, (m_cyc >= 0) ? (32'd1 << m_own) : 32'd0);
        check("done", {28'b0, bus.done_o}, {28'b0, m_done});
        check("err", {31'b0, bus.err_o}, {31'b0, m_err});
        check("rdata", bus.rdata_o, m_rdata);
        if (m_cyc >= 0) begin
            check("paddr", bus.paddr_o, m_addr);
            check("pwdata", bus.pwdata_o, m_wdata);
            check("pwrite", {31'b0, bus.pwrite_o}, {31'b0, m_write});
        end
        // completed requesters drop their request
        for (int k = 0; k < 4; k++) if (m_done[k]) req[k] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!req[k] && $urandom_range(99) < p_req) begin
                req[k] = 1'b1;
                r_addr[k] = $urandom; r_wdata[k] = $urandom; r_wr[k] = 1'($urandom_range(1));
            end
        end
        rdy = ($urandom_range(99) < p_rdy);
        prd = rd_fixed ? rd_val : $urandom;
        bus.req_i = req;
        for (int k = 0; k < 4; k++) begin
            bus.req_addr_i[k*32 +: 32]  = r_addr[k];
            bus.req_wdata_i[k*32 +: 32] = r_wdata[k];
            bus.req_write_i[k]          = r_wr[k];
        end
        bus.pready_i = rdy;
        bus.prdata_i = prd;
        // model advance using the inputs seen at the coming edge
        m_done = 0; m_err = 0;
        if (m_cyc < 0) begin
            found = 0;
            for (int i = 1; i <= 4; i++) begin
                int k;
                k = (m_last + i) % 4;
                if (!found && req[k]) begin
                    found = 1; m_own = k; m_last = k;
                    m_addr = r_addr[k]; m_wdata = r_wdata[k]; m_write = r_wr[k];
                    m_cyc = 0;
                end
            end
        end else if (m_cyc == 0) begin
            m_cyc = 1;
        end else if (rdy) begin
            m_done = 4'(1 << m_own);
            if (!m_write) m_rdata = prd;
            m_cyc = -1;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (m_cyc == TO) begin
            m_done = 4'(1 << m_own);
            m_err = 1'b1;
            m_cyc = -1;
        end
`endif
        else begin
            m_cyc++;
        end
        @(posedge clk);
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d, input logic w);
        req[k] = 1'b1; r_addr[k] = a; r_wdata[k] = d; r_wr[k] = w;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin r_addr[k] = 0; r_wdata[k] = 0; r_wr[k] = 0; end
        p_req = 0; p_rdy = 100; rd_fixed = 0; rd_val = 0;
        reset = 1'b1;
        model_reset();
        #12;
        check("rst_psel", {31'b0, bus.psel_o}, 32'd0);
        check("rst_gnt", {28'b0, bus.gnt_o}, 32'd0);
        check("rst_done", {28'b0, bus.done_o}, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_paddr", bus.paddr_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single read of 0x1000 returning 0xDEADBEEF
        rd_fixed = 1; rd_val = 32'hDEADBEEF;
        set_req(0, 32'h1000, 32'h0, 1'b0);
        repeat (5) step();
        #1 check("read_rdata", bus.rdata_o, 32'hDEADBEEF);
        rd_fixed = 0;

        // all four held: rotation 0,1,2,3,0...
        p_req = 100; p_rdy = 100;
        repeat (16) step();
        p_req = 0;
        repeat (4) step();

        // requester 2 write with 4 wait cycles
        set_req(2, 32'h2000, 32'h55, 1'b1);
        p_rdy = 0;
        repeat (6) step();
        p_rdy = 100;
        repeat (3) step();

        // reset in the middle of an ACCESS phase
        set_req(2, 32'h3000, 32'h1, 1'b1);
        p_rdy = 0;
        repeat (4) step();
        #2 reset = 1'b1;
        #1;
        check("rst_mid_psel", {31'b0, bus.psel_o}, 32'd0);
        check("rst_mid_pen", {31'b0, bus.penable_o}, 32'd0);
        check("rst_mid_gnt", {28'b0, bus.gnt_o}, 32'd0);
        check("rst_mid_done", {28'b0, bus.done_o}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        set_req(1, 32'h4000, 32'h0, 1'b0);
        set_req(0, 32'h5000, 32'h0, 1'b0);
        p_rdy = 100;
        repeat (8) step();

        // stalled completer: timeout abort or indefinite wait
        set_req(1, 32'h6000, 32'h77, 1'b1);
        set_req(3, 32'h7000, 32'h0, 1'b0);
        p_rdy = 0;
        repeat (120) step();
        p_rdy = 100;
        repeat (10) step();

        // randomized traffic
        p_req = 30; p_rdy = 50;
        repeat (3000) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS cycles without pready_i before abort (used only with APB_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_i  input  4  per-requester transfer request, held until matching done_o.
REQ-005 SHALL have port req_write_i  input  4  per-requester direction, 1=write.
REQ-006 SHALL have port req_addr_i  input  128  four packed 32-bit addresses, requester k at bits [32k+31:32k].
REQ-007 SHALL have port req_wdata_i  input  128  four packed 32-bit write data, same packing.
REQ-008 SHALL have port gnt_o  output  4  one-hot grant, requester currently owning the APB bus.
REQ-009 SHALL have port done_o  output  4  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rdata_o  output  32  last completed read data.
REQ-011 SHALL have port err_o  output  1  timeout-abort flag, valid with done_o.
REQ-012 SHALL have ports psel_o, penable_o, pwrite_o (output 1), paddr_o, pwdata_o (output 32), pready_i (input 1), prdata_i (input 32): APB master signals.

Function
REQ-013 SHALL implement states IDLE, SETUP, ACCESS; IDLE->SETUP when any req_i bit set; SETUP->ACCESS unconditionally; ACCESS->IDLE on pready_i=1 (or timeout), else stay.
REQ-014 SHALL select in IDLE by round-robin: search starts at (last granted index + 1) mod 4; after reset last granted = 3, so requester 0 has first priority.
REQ-015 SHALL register winner's address, wdata, write bit and one-hot grant at the IDLE->SETUP edge; paddr_o/pwdata_o/pwrite_o driven from these registers, stable through SETUP and ACCESS.
REQ-016 SHALL drive psel_o=1 in SETUP and ACCESS, penable_o=1 only in ACCESS, both 0 in IDLE.
REQ-017 SHALL assert gnt_o in SETUP and ACCESS only; gnt_o=0 in IDLE.
REQ-018 SHALL, on the edge completing ACCESS, pulse done_o[k] high for exactly one cycle (the following cycle, state IDLE); for reads, load rdata_o from prdata_i on that same edge; rdata_o holds otherwise, unchanged by writes.
REQ-019 SHALL sample req_i only in IDLE; req_i changes during SETUP/ACCESS do not affect the transfer in flight; a dropped request still completes.
REQ-020 SHALL allow back-to-back transfers: IDLE with pending request goes directly to SETUP, giving minimum 3 cycles per transfer with pready_i=1.
REQ-021 SHALL ignore pready_i outside ACCESS.
REQ-022 SHALL update the round-robin pointer at grant time, so a requester holding req_i continuously cannot win twice while another requester is pending.

Reset
REQ-023 SHALL, on reset assertion (asynchronously, including mid-transfer), force state IDLE, psel_o=0, penable_o=0, gnt_o=0, done_o=0, err_o=0, rdata_o=0, paddr_o=0, pwdata_o=0, pwrite_o=0, pointer=3, timeout counter=0.
REQ-024 SHALL produce no done_o pulse for a transfer aborted by reset.

Configuration
REQ-025 SHALL, with APB_ARB_TIMEOUT_EN defined, count ACCESS cycles; when TIMEOUT_CYCLES consecutive ACCESS cycles elapse with pready_i=0, return to IDLE, pulse done_o[k] and err_o together for one cycle, leave rdata_o unchanged; counter clears on entering ACCESS.
REQ-026 SHALL, with APB_ARB_TIMEOUT_EN defined, treat pready_i=1 in the final counted cycle as normal completion (err_o=0).
REQ-027 SHALL, without APB_ARB_TIMEOUT_EN, tie err_o to 0, omit the counter, and wait in ACCESS indefinitely.

Verification
REQ-028 SHALL cover: reset, req_i=0001 read addr 0x1000, pready_i=1 first ACCESS cycle, prdata_i=0xDEADBEEF -> psel_o cycles 1-2, penable_o cycle 2, done_o=0001 cycle 3, rdata_o=0xDEADBEEF.
REQ-029 SHALL cover: req_i=1111 held, pready_i=1 -> grants 0,1,2,3,0 in order, one every 3 cycles, each done_o single-cycle.
REQ-030 SHALL cover: requester 2 write 0x55 to 0x2000, pready_i low 4 ACCESS cycles -> paddr_o/pwdata_o/psel_o stable throughout, done_o=0100 after pready_i, rdata_o unchanged.
REQ-031 SHALL cover: reset asserted during ACCESS -> psel_o/penable_o/gnt_o 0 immediately, no done_o, next transfer grants requester 0.
REQ-032 SHALL cover (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready_i held 0 -> after 16 ACCESS cycles done_o and err_o pulse, state IDLE, next requester served; without macro, same stimulus keeps ACCESS for 100+ cycles, err_o=0.
